// File: rtl/axi_rd_arbiter.sv
// Two-to-one AXI4 read-channel arbiter shared by the Icache and the Dcache.
// Round-robin grant, one outstanding transaction, R beats routed to the owner until rlast.
module axi_rd_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RR_RESET_PRI = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_arvalid,
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [7:0]        i_arlen,
    output logic              i_arready,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rvalid,
    output logic              i_rlast,
    input  logic              i_rready,
    input  logic              d_arvalid,
    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [7:0]        d_arlen,
    output logic              d_arready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rvalid,
    output logic              d_rlast,
    input  logic              d_rready,
    output logic              arvalid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [3:0]        arid,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    input  logic [3:0]        rid,
    output logic              rready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_e;

    localparam logic RST_PRI = (RR_RESET_PRI != 0);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              pri_q, pri_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              gnt_s;
    logic              gnt_dc_s;
    logic              in_r_s;
    logic              rready_s;
    logic              unused_s;

    // Single outstanding transaction: response id and status carry no routing information.
    assign unused_s = ^{rresp, rid};

    assign in_r_s   = (state_q == S_R);
    assign rready_s = in_r_s & (owner_q ? d_rready : i_rready);

    // Next-state, grant decision and request capture.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        pri_d    = pri_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        gnt_s    = 1'b0;
        gnt_dc_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Gated by rstn so no requester sees a handshake that reset will discard.
                gnt_s    = rstn & (i_arvalid | d_arvalid);
                gnt_dc_s = (i_arvalid & d_arvalid) ? pri_q : d_arvalid;
                if (gnt_s) begin
                    state_d  = S_AR;
                    owner_d  = gnt_dc_s;
                    araddr_d = gnt_dc_s ? d_araddr : i_araddr;
                    arlen_d  = gnt_dc_s ? d_arlen : i_arlen;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (rvalid & rready_s & rlast) begin
                    state_d = S_IDLE;
                    pri_d   = ~owner_q;
                end else begin
                    state_d = S_R;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and AR payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            pri_q    <= RST_PRI;
            araddr_q <= '0;
            arlen_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            pri_q    <= pri_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
        end
    end

    assign i_arready = gnt_s & ~gnt_dc_s;
    assign d_arready = gnt_s & gnt_dc_s;

    assign arvalid = (state_q == S_AR);
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arid    = {3'b000, owner_q};
    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign rready   = rready_s;
    assign i_rdata  = rdata;
    assign d_rdata  = rdata;
    assign i_rvalid = in_r_s & ~owner_q & rvalid;
    assign i_rlast  = in_r_s & ~owner_q & rlast;
    assign d_rvalid = in_r_s & owner_q & rvalid;
    assign d_rlast  = in_r_s & owner_q & rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: vector table, directed corner sequences and a
// randomized phase checked against a transaction-level round-robin model.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_arvalid, d_arvalid, i_arready, d_arready;
    logic [31:0] i_araddr, d_araddr, i_rdata, d_rdata;
    logic [7:0]  i_arlen, d_arlen;
    logic        i_rvalid, i_rlast, i_rready, d_rvalid, d_rlast, d_rready;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [3:0]  arid, rid;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;

    int tests = 0;
    int fails = 0;
    bit pri_m;

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_RESET_PRI(1)) dut (
        .clk(clk), .rstn(rstn),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rready(i_rready),
        .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rready(d_rready),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arid(arid), .arsize(arsize),
        .arburst(arburst), .arready(arready), .rdata(rdata), .rvalid(rvalid), .rlast(rlast),
        .rresp(rresp), .rid(rid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          use_d;
        logic [31:0] addr;
        logic [7:0]  len;
        int          ar_delay;
        logic [3:0]  exp_arid;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Expects the DUT idle with requests already driven; runs one full transaction.
    task automatic run_txn(input bit exp_d, input logic [31:0] exp_addr, input logic [7:0] exp_len,
                           input int ar_delay, input int stall_beat, input int stall_len,
                           input int raise_beat, input bit rnd);
        int          nbeats;
        int          ngap;
        logic [31:0] dat;
        bit          is_last;
        nbeats = int'(exp_len) + 1;
        #1;
        check("grant", {i_arready, d_arready}, exp_d ? 2'b01 : 2'b10);
        step();
        if (exp_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
        for (int c = 0; c <= ar_delay; c++) begin
            arready = (c == ar_delay);
            #1;
            check("arvalid", arvalid, 1'b1);
            check("araddr", araddr, exp_addr);
            check("arlen", arlen, exp_len);
            check("arid", arid, {3'b000, exp_d});
            check("arsize_arburst", {arsize, arburst}, {3'b010, 2'b01});
            check("arready_busy", {i_arready, d_arready}, 2'b00);
            check("rready_in_ar", rready, 1'b0);
            step();
        end
        arready = 1'b0;
        #1;
        check("arvalid_drop", arvalid, 1'b0);
        for (int b = 0; b < nbeats; b++) begin
            if (raise_beat == b) begin
                if (exp_d) begin
                    i_arvalid = 1'b1; i_araddr = 32'h0000_0400; i_arlen = 8'd3;
                end else begin
                    d_arvalid = 1'b1; d_araddr = 32'h0000_0400; d_arlen = 8'd3;
                end
            end
            ngap = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < ngap; g++) begin
                rvalid = 1'b0; rlast = 1'b0;
                #1;
                check("owner_rvalid_gap", exp_d ? d_rvalid : i_rvalid, 1'b0);
                step();
            end
            dat     = rnd ? $urandom : 32'hA0 + 32'(b);
            is_last = (b == nbeats - 1);
            rvalid  = 1'b1; rdata = dat; rlast = is_last;
            if (exp_d) i_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            else       d_rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    if (exp_d) d_rready = 1'b0; else i_rready = 1'b0;
                    #1;
                    check("rready_stall", rready, 1'b0);
                    check("owner_rvalid_stall", exp_d ? d_rvalid : i_rvalid, 1'b1);
                    check("owner_rdata_stall", exp_d ? d_rdata : i_rdata, dat);
                    check("other_rvalid_stall", exp_d ? i_rvalid : d_rvalid, 1'b0);
                    step();
                end
            end
            if (exp_d) d_rready = 1'b1; else i_rready = 1'b1;
            #1;
            check("rready_beat", rready, 1'b1);
            check("owner_rvalid", exp_d ? d_rvalid : i_rvalid, 1'b1);
            check("owner_rdata", exp_d ? d_rdata : i_rdata, dat);
            check("owner_rlast", exp_d ? d_rlast : i_rlast, is_last);
            check("other_rvalid", exp_d ? i_rvalid : d_rvalid, 1'b0);
            check("other_rlast", exp_d ? i_rlast : d_rlast, 1'b0);
            check("arready_in_r", {i_arready, d_arready}, 2'b00);
            step();
        end
        rvalid = 1'b0; rlast = 1'b0; i_rready = 1'b1; d_rready = 1'b1;
        #1;
        check("idle_after_last", {rready, arvalid}, 2'b00);
        pri_m = ~exp_d;
    endtask

    bit          pend_i, pend_d, win_d;
    logic [31:0] addr_i, addr_d;
    logic [7:0]  len_i, len_d;

    initial begin
        vecs[0] = '{use_d: 1'b0, addr: 32'h1C00_0010, len: 8'd3, ar_delay: 1, exp_arid: 4'd0};
        vecs[1] = '{use_d: 1'b1, addr: 32'h8000_0020, len: 8'd3, ar_delay: 0, exp_arid: 4'd1};
        vecs[2] = '{use_d: 1'b1, addr: 32'h0000_1000, len: 8'd0, ar_delay: 0, exp_arid: 4'd1};
        vecs[3] = '{use_d: 1'b0, addr: 32'hFFFF_FFFC, len: 8'd7, ar_delay: 2, exp_arid: 4'd0};

        rstn = 1'b0;
        i_arvalid = 1'b1; i_araddr = 32'h0; i_arlen = 8'd0; i_rready = 1'b1;
        d_arvalid = 1'b0; d_araddr = 32'h0; d_arlen = 8'd0; d_rready = 1'b1;
        arready = 1'b0; rdata = 32'h0; rvalid = 1'b1; rlast = 1'b0;
        rresp = 2'b00; rid = 4'd0;
        step();
        step();
        #1;
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_araddr", araddr, 32'h0);
        check("rst_arlen_arid", {arlen, arid}, 12'h000);
        check("rst_arready", {i_arready, d_arready}, 2'b00);
        check("rst_rvalid", {i_rvalid, d_rvalid, rready}, 3'b000);
        rstn = 1'b1; i_arvalid = 1'b0; rvalid = 1'b0;
        pri_m = 1'b1;
        step();

        // Simultaneous pairs: Dcache first after reset, then alternation.
        i_arvalid = 1'b1; i_araddr = 32'h1000_0000; i_arlen = 8'd3;
        d_arvalid = 1'b1; d_araddr = 32'h2000_0000; d_arlen = 8'd1;
        run_txn(1'b1, 32'h2000_0000, 8'd1, 0, -1, 0, -1, 1'b0);
        run_txn(1'b0, 32'h1000_0000, 8'd3, 0, -1, 0, -1, 1'b0);
        i_arvalid = 1'b1; i_araddr = 32'h1000_0040; i_arlen = 8'd3;
        d_arvalid = 1'b1; d_araddr = 32'h2000_0040; d_arlen = 8'd2;
        run_txn(1'b1, 32'h2000_0040, 8'd2, 1, -1, 0, -1, 1'b0);
        run_txn(1'b0, 32'h1000_0040, 8'd3, 0, -1, 0, -1, 1'b0);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].use_d) begin
                d_arvalid = 1'b1; d_araddr = vecs[v].addr; d_arlen = vecs[v].len;
            end else begin
                i_arvalid = 1'b1; i_araddr = vecs[v].addr; i_arlen = vecs[v].len;
            end
            run_txn(vecs[v].exp_arid[0], vecs[v].addr, vecs[v].len, vecs[v].ar_delay,
                    -1, 0, -1, 1'b0);
        end

        // Icache stalls beat 2 for three cycles.
        i_arvalid = 1'b1; i_araddr = 32'h1C00_0100; i_arlen = 8'd3;
        run_txn(1'b0, 32'h1C00_0100, 8'd3, 0, 1, 3, -1, 1'b0);

        // Dcache request raised mid Icache burst, served right after.
        i_arvalid = 1'b1; i_araddr = 32'h1C00_0200; i_arlen = 8'd3;
        run_txn(1'b0, 32'h1C00_0200, 8'd3, 0, -1, 0, 1, 1'b0);
        run_txn(1'b1, 32'h0000_0400, 8'd3, 0, -1, 0, -1, 1'b0);

        // Reset during beat 2 of an Icache burst.
        i_arvalid = 1'b1; i_araddr = 32'h1C00_0300; i_arlen = 8'd3;
        #1;
        check("rst_seq_grant", i_arready, 1'b1);
        step();
        i_arvalid = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hA0; rlast = 1'b0;
        #1;
        check("rst_seq_beat1", i_rvalid, 1'b1);
        step();
        rdata = 32'hA1; rstn = 1'b0;
        step();
        rstn = 1'b1;
        #1;
        check("midrst_arvalid", arvalid, 1'b0);
        check("midrst_rvalid", {i_rvalid, d_rvalid, i_rlast}, 3'b000);
        check("midrst_rready", rready, 1'b0);
        rvalid = 1'b0;
        pri_m = 1'b1;
        i_arvalid = 1'b1; i_araddr = 32'h1C00_0400; i_arlen = 8'd3;
        d_arvalid = 1'b1; d_araddr = 32'h0000_0800; d_arlen = 8'd0;
        run_txn(1'b1, 32'h0000_0800, 8'd0, 0, -1, 0, -1, 1'b0);
        run_txn(1'b0, 32'h1C00_0400, 8'd3, 0, -1, 0, -1, 1'b0);

        // Random traffic against the round-robin model.
        pend_i = 1'b0; pend_d = 1'b0;
        for (int it = 0; it < 40; it++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1'b1; addr_i = $urandom; len_i = 8'($urandom_range(0, 3));
            end
            if (!pend_d && $urandom_range(0, 1) == 1) begin
                pend_d = 1'b1; addr_d = $urandom; len_d = 8'($urandom_range(0, 3));
            end
            if (!pend_i && !pend_d) begin
                pend_i = 1'b1; addr_i = $urandom; len_i = 8'($urandom_range(0, 3));
            end
            i_arvalid = pend_i; i_araddr = addr_i; i_arlen = len_i;
            d_arvalid = pend_d; d_araddr = addr_d; d_arlen = len_d;
            win_d = (pend_i && pend_d) ? pri_m : pend_d;
            run_txn(win_d, win_d ? addr_d : addr_i, win_d ? len_d : len_i,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), -1, 1'b1);
            if (win_d) pend_d = 1'b0; else pend_i = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
